// File: rtl/timer_tick_sequencer.sv
// Avalon-MM master that programs the interval timer, services its timeout
// interrupts for a requested number of ticks (or until abort), then stops it.
module timer_tick_sequencer #(
  parameter int TICK_W     = 16,
  parameter int PERIOD_MIN = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic [31:0]       cmd_period,
  input  logic [TICK_W-1:0] cmd_ticks,
  input  logic              cmd_abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [TICK_W-1:0] tick_count,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic              tmr_irq
);

  // Handshake: the timer slave has no waitrequest, so every write state
  // presents chipselect=1/write_n=0 for exactly one cycle and the write is taken.
  typedef enum logic [2:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_WAIT_IRQ, S_CLR_STAT, S_WR_STOP, S_DONE
  } state_t;

  localparam logic [31:0] PMIN = 32'(PERIOD_MIN);

  state_t            state, state_d;
  logic [31:0]       period_q, period_d;
  logic [TICK_W-1:0] ticks_q;
  logic              count_en;
  logic              abort_hit;
  logic              start_acc;

  always_comb begin
    state_d   = state;
    period_d  = period_q;
    count_en  = 1'b0;
    abort_hit = 1'b0;
    start_acc = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_start) begin
          start_acc = 1'b1;
          state_d   = S_WR_PL;
          period_d  = (cmd_period < PMIN) ? PMIN : cmd_period;
        end
      end
      S_WR_PL:   state_d = cmd_abort ? S_WR_STOP : S_WR_PH;
      S_WR_PH:   state_d = cmd_abort ? S_WR_STOP : S_WR_CTRL;
      S_WR_CTRL: state_d = cmd_abort ? S_WR_STOP : S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        // Abort takes priority: a coincident irq is left uncounted.
        if (cmd_abort) begin
          state_d = S_WR_STOP;
        end else if (tmr_irq) begin
          count_en = 1'b1;
          state_d  = S_CLR_STAT;
        end
      end
      S_CLR_STAT: begin
        if (cmd_abort)
          state_d = S_WR_STOP;
        else if (ticks_q != '0 && tick_count == ticks_q)
          state_d = S_WR_STOP;
        else
          state_d = S_WAIT_IRQ;
      end
      S_WR_STOP: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (cmd_abort && (state == S_WR_PL || state == S_WR_PH || state == S_WR_CTRL ||
                      state == S_WAIT_IRQ || state == S_CLR_STAT))
      abort_hit = 1'b1;
  end

  // Outputs are registered from the next state so they line up with that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      period_q       <= '0;
      ticks_q        <= '0;
      tick_count     <= '0;
      aborted        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      tmr_address    <= 3'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= 16'h0000;
    end else begin
      state    <= state_d;
      period_q <= period_d;
      if (start_acc) begin
        ticks_q    <= cmd_ticks;
        tick_count <= '0;
        aborted    <= 1'b0;
      end
      if (count_en && tick_count != '1)
        tick_count <= tick_count + 1'b1;
      if (abort_hit)
        aborted <= 1'b1;

      busy           <= (state_d != S_IDLE);
      done           <= (state_d == S_DONE);
      tmr_address    <= 3'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= 16'h0000;
      case (state_d)
        S_WR_PL: begin
          tmr_address    <= 3'd2;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_writedata  <= period_d[15:0];
        end
        S_WR_PH: begin
          tmr_address    <= 3'd3;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_writedata  <= period_d[31:16];
        end
        S_WR_CTRL: begin
          tmr_address    <= 3'd1;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_writedata  <= 16'h0007;
        end
        S_CLR_STAT: begin
          tmr_address    <= 3'd0;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_writedata  <= 16'h0000;
        end
        S_WR_STOP: begin
          tmr_address    <= 3'd1;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_writedata  <= 16'h0008;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_tick_sequencer.sv
// Directed bench for timer_tick_sequencer: bus writes, tick counting, abort paths.
module tb_timer_tick_sequencer;

  localparam int TICK_W = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_start;
  logic [31:0]       cmd_period;
  logic [TICK_W-1:0] cmd_ticks;
  logic              cmd_abort;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [TICK_W-1:0] tick_count;
  logic [2:0]        tmr_address;
  logic              tmr_chipselect;
  logic              tmr_write_n;
  logic [15:0]       tmr_writedata;
  logic              tmr_irq;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic done_ab = 1'b0;

  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];

  timer_tick_sequencer #(.TICK_W(TICK_W), .PERIOD_MIN(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_period(cmd_period),
    .cmd_ticks(cmd_ticks), .cmd_abort(cmd_abort), .busy(busy), .done(done),
    .aborted(aborted), .tick_count(tick_count), .tmr_address(tmr_address),
    .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // bus and completion monitor, sampled 1ns after the active edge
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      if (tmr_chipselect && !tmr_write_n)
        obs_q.push_back({tmr_address, tmr_writedata});
      if (done) begin
        done_cnt = done_cnt + 1;
        done_ab  = aborted;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start_cmd(input logic [31:0] p, input logic [TICK_W-1:0] t);
    @(negedge clk);
    cmd_start  = 1'b1;
    cmd_period = p;
    cmd_ticks  = t;
    @(negedge clk);
    cmd_start  = 1'b0;
  endtask

  task automatic fire_irq(input logic with_abort);
    @(negedge clk);
    tmr_irq   = 1'b1;
    cmd_abort = with_abort;
    @(negedge clk);
    tmr_irq   = 1'b0;
    cmd_abort = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  function automatic void push_exp(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endfunction

  // scoreboard drain
  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_write"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  int dc0;

  initial begin
    reset_n    = 1'b0;
    cmd_start  = 1'b0;
    cmd_period = '0;
    cmd_ticks  = '0;
    cmd_abort  = 1'b0;
    tmr_irq    = 1'b0;
    cycles(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_tick_count", 32'(tick_count), 32'd0);
    check("rst_cs", 32'(tmr_chipselect), 32'd0);
    check("rst_write_n", 32'(tmr_write_n), 32'd1);
    check("rst_addr", 32'(tmr_address), 32'd0);
    check("rst_wdata", 32'(tmr_writedata), 32'd0);
    reset_n = 1'b1;
    cycles(2);

    // 1: three ticks, large period; first write visible the cycle after start
    dc0 = done_cnt;
    start_cmd(32'h0001_86A0, 16'd3);
    check("t1_lat_cs", 32'(tmr_chipselect), 32'd1);
    check("t1_lat_addr", 32'(tmr_address), 32'd2);
    check("t1_lat_busy", 32'(busy), 32'd1);
    cycles(4);
    for (int i = 0; i < 3; i++) begin
      fire_irq(1'b0);
      cycles(2);
    end
    wait_idle("t1", 20);
    push_exp(3'd2, 16'h86A0); push_exp(3'd3, 16'h0001); push_exp(3'd1, 16'h0007);
    push_exp(3'd0, 16'h0000); push_exp(3'd0, 16'h0000); push_exp(3'd0, 16'h0000);
    push_exp(3'd1, 16'h0008);
    check_writes("t1");
    check("t1_done_cnt", 32'(done_cnt - dc0), 32'd1);
    check("t1_aborted", 32'(done_ab), 32'd0);
    check("t1_tick_count", 32'(tick_count), 32'd3);

    // 2: period 0 is clamped to 2
    dc0 = done_cnt;
    start_cmd(32'h0000_0000, 16'd1);
    cycles(4);
    fire_irq(1'b0);
    wait_idle("t2", 20);
    push_exp(3'd2, 16'h0002); push_exp(3'd3, 16'h0000); push_exp(3'd1, 16'h0007);
    push_exp(3'd0, 16'h0000); push_exp(3'd1, 16'h0008);
    check_writes("t2");
    check("t2_done_cnt", 32'(done_cnt - dc0), 32'd1);
    check("t2_tick_count", 32'(tick_count), 32'd1);

    // 3: free-run, abort after five ticks, later irq ignored
    dc0 = done_cnt;
    start_cmd(32'h0000_000A, 16'd0);
    cycles(4);
    for (int i = 0; i < 5; i++) begin
      fire_irq(1'b0);
      cycles(3);
    end
    check("t3_busy_freerun", 32'(busy), 32'd1);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    wait_idle("t3", 20);
    fire_irq(1'b0);
    cycles(3);
    push_exp(3'd2, 16'h000A); push_exp(3'd3, 16'h0000); push_exp(3'd1, 16'h0007);
    for (int i = 0; i < 5; i++) push_exp(3'd0, 16'h0000);
    push_exp(3'd1, 16'h0008);
    check_writes("t3");
    check("t3_done_cnt", 32'(done_cnt - dc0), 32'd1);
    check("t3_aborted", 32'(done_ab), 32'd1);
    check("t3_tick_count", 32'(tick_count), 32'd5);
    check("t3_busy_after", 32'(busy), 32'd0);

    // 4: abort coincident with irq in WAIT_IRQ
    dc0 = done_cnt;
    start_cmd(32'h0000_0010, 16'd0);
    cycles(4);
    fire_irq(1'b0);
    cycles(3);
    fire_irq(1'b1);
    wait_idle("t4", 20);
    push_exp(3'd2, 16'h0010); push_exp(3'd3, 16'h0000); push_exp(3'd1, 16'h0007);
    push_exp(3'd0, 16'h0000); push_exp(3'd1, 16'h0008);
    check_writes("t4");
    check("t4_aborted", 32'(done_ab), 32'd1);
    check("t4_tick_count", 32'(tick_count), 32'd1);

    // 5: abort (with a stray start) during WR_PH
    dc0 = done_cnt;
    start_cmd(32'h0003_0004, 16'd2);
    @(negedge clk);
    cmd_abort  = 1'b1;
    cmd_start  = 1'b1;
    cmd_period = 32'h0000_0055;
    @(negedge clk);
    cmd_abort  = 1'b0;
    cmd_start  = 1'b0;
    wait_idle("t5", 20);
    cycles(3);
    push_exp(3'd2, 16'h0004); push_exp(3'd3, 16'h0003); push_exp(3'd1, 16'h0008);
    check_writes("t5");
    check("t5_done_cnt", 32'(done_cnt - dc0), 32'd1);
    check("t5_aborted", 32'(done_ab), 32'd1);
    check("t5_tick_count", 32'(tick_count), 32'd0);
    check("t5_busy_after", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
